// File: rtl/sound_sample_sequencer.sv
// ---------------------------------------------------------------------------
// sound_sample_sequencer
//
// Plays back up to three digitised effect voices (0 = explosion, 1 = shell
// fire, 2 = engine) from one shared single-port sample BRAM.  On every
// 48 kHz sample tick the sequencer reads one byte per voice.  It then mixes
// the three unsigned 8-bit samples into a signed 16-bit stream.  The ROM
// downloader shares the BRAM port and always takes priority over playback.
//
// Ports
//   clk           system clock (only clock)
//   rst           synchronous active-high reset
//   clk_48KHz_en  one-cycle sample tick
//   trig[2:0]     per-voice trigger levels; a rising edge arms the voice
//   dl_wr         download write strobe
//   dl_addr       download byte address (out-of-range addresses are dropped)
//   dl_data       download byte
//   rom_addr      BRAM address (download address or playback pointer)
//   rom_we        BRAM write enable
//   rom_wdata     BRAM write data
//   rom_rdata     BRAM read data, valid one cycle after rom_addr
//   voice_active  voice n is currently playing
//   audio_out     signed mix, the 10-bit sum placed in the top bits
// ---------------------------------------------------------------------------
module sound_sample_sequencer #(
    parameter int                ADDR_W   = 14,
    parameter logic [ADDR_W-1:0] V0_START = 14'h0000,
    parameter logic [ADDR_W-1:0] V0_END   = 14'h0FFF,
    parameter logic [ADDR_W-1:0] V1_START = 14'h1000,
    parameter logic [ADDR_W-1:0] V1_END   = 14'h1FFF,
    parameter logic [ADDR_W-1:0] V2_START = 14'h2000,
    parameter logic [ADDR_W-1:0] V2_END   = 14'h3FFF,
    parameter bit                V2_LOOP  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_48KHz_en,
    input  logic [2:0]        trig,
    input  logic              dl_wr,
    input  logic [24:0]       dl_addr,
    input  logic [7:0]        dl_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_we,
    output logic [7:0]        rom_wdata,
    input  logic [7:0]        rom_rdata,
    output logic [2:0]        voice_active,
    output logic [15:0]       audio_out
);

    typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_RD2, S_CAP, S_MIX} state_t;

    state_t            state_q;
    logic              cap_vld_q;   // a read was issued last cycle
    logic [1:0]        cap_sel_q;   // ...for this voice
    logic [15:0]       audio_q;

    logic              wr_ok;
    logic              in_rd;
    logic              stall;
    logic              tick_start;
    logic [1:0]        rd_sel;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] ptr_w  [3];
    logic signed [7:0] term_w [3];
    logic [9:0]        mix_d;

    // Only addresses inside the BRAM are written; others are dropped entirely.
    assign wr_ok      = dl_wr && (dl_addr[24:ADDR_W] == '0);
    assign in_rd      = (state_q == S_RD0) || (state_q == S_RD1) || (state_q == S_RD2);
    assign stall      = wr_ok && in_rd;
    assign tick_start = (state_q == S_IDLE) && clk_48KHz_en;

    always_comb begin
        rd_sel  = 2'd0;
        rd_addr = '0;
        case (state_q)
            S_RD0: begin rd_sel = 2'd0; rd_addr = ptr_w[0]; end
            S_RD1: begin rd_sel = 2'd1; rd_addr = ptr_w[1]; end
            S_RD2: begin rd_sel = 2'd2; rd_addr = ptr_w[2]; end
            default: begin rd_sel = 2'd0; rd_addr = '0; end
        endcase
    end

    // BRAM port mux: the downloader owns the port in any cycle it writes.
    always_comb begin
        rom_we    = wr_ok;
        rom_wdata = 8'h00;
        rom_addr  = rd_addr;
        if (wr_ok) begin
            rom_addr  = dl_addr[ADDR_W-1:0];
            rom_wdata = dl_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cap_vld_q <= 1'b0;
            cap_sel_q <= 2'd0;
            audio_q   <= 16'h0000;
        end else begin
            // A read stolen by the downloader yields no data for the next cycle.
            cap_vld_q <= in_rd && !wr_ok;
            cap_sel_q <= rd_sel;
            case (state_q)
                S_IDLE: if (clk_48KHz_en) state_q <= S_RD0;
                S_RD0:  if (!stall) state_q <= S_RD1;
                S_RD1:  if (!stall) state_q <= S_RD2;
                S_RD2:  if (!stall) state_q <= S_CAP;
                S_CAP:  state_q <= S_MIX;
                S_MIX: begin
                    audio_q <= {mix_d, 6'b000000};
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_voice
            localparam logic [ADDR_W-1:0] START_P = (gi == 0) ? V0_START :
                                                    (gi == 1) ? V1_START : V2_START;
            localparam logic [ADDR_W-1:0] END_P   = (gi == 0) ? V0_END :
                                                    (gi == 1) ? V1_END : V2_END;
            localparam bit                LOOP_P  = (gi == 2) && V2_LOOP;

            logic [ADDR_W-1:0] ptr_q;
            logic [ADDR_W-1:0] ptr_d;
            logic              active_q;
            logic              active_d;
            logic              pend_q;
            logic              trig_q;
            logic [7:0]        smp_q;
            logic              rise;
            logic              cap_hit;

            assign rise    = trig[gi] && !trig_q;
            assign cap_hit = cap_vld_q && (cap_sel_q == 2'(gi));

            // Pointer step after a captured sample; END either wraps (held
            // looping voice) or ends the voice with the pointer parked.
            always_comb begin
                ptr_d    = ptr_q + ADDR_W'(1);
                active_d = active_q;
                if (ptr_q == END_P) begin
                    if (LOOP_P && trig[gi]) begin
                        ptr_d = START_P;
                    end else begin
                        ptr_d    = ptr_q;
                        active_d = 1'b0;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    ptr_q    <= START_P;
                    active_q <= 1'b0;
                    pend_q   <= 1'b0;
                    trig_q   <= 1'b0;
                    smp_q    <= 8'h80;
                end else begin
                    trig_q <= trig[gi];
                    if (tick_start && pend_q) begin
                        ptr_q    <= START_P;
                        active_q <= 1'b1;
                        pend_q   <= rise;
                    end else begin
                        pend_q <= pend_q || rise;
                    end
                    if (cap_hit) begin
                        if (active_q) begin
                            smp_q    <= rom_rdata;
                            ptr_q    <= ptr_d;
                            active_q <= active_d;
                        end else begin
                            smp_q <= 8'h80;
                        end
                    end
                end
            end

            assign ptr_w[gi]        = ptr_q;
            // Offset-binary to two's complement: sample - 8'h80.
            assign term_w[gi]       = signed'({~smp_q[7], smp_q[6:0]});
            assign voice_active[gi] = active_q;
        end
    endgenerate

    // Three signed 8-bit terms fit a 10-bit sum without overflow.
    always_comb begin
        mix_d = '0;
        for (int n = 0; n < 3; n++) begin
            mix_d = mix_d + {{2{term_w[n][7]}}, term_w[n]};
        end
    end

    assign audio_out = audio_q;

endmodule

// File: tb/tb_sound_sample_sequencer.sv
module tb_sound_sample_sequencer;

    logic        clk;
    logic        rst;
    logic        tick;
    logic [2:0]  trig;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic [13:0] rom_addr;
    logic        rom_we;
    logic [7:0]  rom_wdata;
    logic [7:0]  rom_rdata;
    logic [2:0]  voice_active;
    logic [15:0] audio_out;

    sound_sample_sequencer #(
        .ADDR_W  (14),
        .V0_START(14'h0000), .V0_END(14'h0FFF),
        .V1_START(14'h1000), .V1_END(14'h1002),
        .V2_START(14'h2000), .V2_END(14'h2003),
        .V2_LOOP (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_48KHz_en(tick),
        .trig        (trig),
        .dl_wr       (dl_wr),
        .dl_addr     (dl_addr),
        .dl_data     (dl_data),
        .rom_addr    (rom_addr),
        .rom_we      (rom_we),
        .rom_wdata   (rom_wdata),
        .rom_rdata   (rom_rdata),
        .voice_active(voice_active),
        .audio_out   (audio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample BRAM with registered read.
    logic [7:0] bram [0:16383];
    always @(posedge clk) begin
        if (rom_we) bram[rom_addr] <= rom_wdata;
        rom_rdata <= bram[rom_addr];
    end

    int total = 0;
    int bad   = 0;

    // Behavioural model state.
    logic [7:0]  mdl_mem [0:16383];
    logic [13:0] m_start [3] = '{14'h0000, 14'h1000, 14'h2000};
    logic [13:0] m_end   [3] = '{14'h0FFF, 14'h1002, 14'h2003};
    logic [13:0] m_ptr   [3];
    logic [2:0]  m_act;
    logic [2:0]  m_pend;
    logic [2:0]  m_trig;
    logic [15:0] m_new_audio;
    logic [2:0]  exp_active;
    logic [15:0] exp_audio;
    bit          busy     = 1'b1;
    bit          checking = 1'b0;
    logic        exp_we;
    int          tick_no  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_act      = 3'b000;
        m_pend     = 3'b000;
        m_trig     = 3'b000;
        exp_active = 3'b000;
        exp_audio  = 16'h0000;
    endtask

    // One tick of playback: arm pending voices, fetch one sample each, mix.
    task automatic model_tick();
        int sum;
        int s;
        sum = 0;
        for (int n = 0; n < 3; n++) begin
            if (m_pend[n]) begin
                m_ptr[n]  = m_start[n];
                m_act[n]  = 1'b1;
                m_pend[n] = 1'b0;
            end
        end
        for (int n = 0; n < 3; n++) begin
            s = 128;
            if (m_act[n]) begin
                s = int'(mdl_mem[m_ptr[n]]);
                if (m_ptr[n] == m_end[n]) begin
                    if (n == 2 && m_trig[2]) m_ptr[n] = m_start[n];
                    else                     m_act[n] = 1'b0;
                end else begin
                    m_ptr[n] = m_ptr[n] + 14'd1;
                end
            end
            sum = sum + (s - 128);
        end
        m_new_audio = 16'(sum * 64);
    endtask

    // Every-cycle checks: port arbitration always, steady outputs when idle.
    always @(negedge clk) begin
        if (checking && !rst) begin
            exp_we = dl_wr && (dl_addr < 25'h4000);
            chk("rom_we", 32'(rom_we), 32'(exp_we));
            if (exp_we) begin
                chk("rom_addr_wr", 32'(rom_addr), 32'(dl_addr[13:0]));
                chk("rom_wdata", 32'(rom_wdata), 32'(dl_data));
            end
            if (!busy) begin
                chk("voice_active", 32'(voice_active), 32'(exp_active));
                chk("audio_out", 32'(audio_out), 32'(exp_audio));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        busy  = 1'b1;
        rst   = 1'b1;
        tick  = 1'b0;
        trig  = 3'b000;
        dl_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        busy = 1'b0;
    endtask

    task automatic dl_write(input logic [24:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        if (a < 25'h4000) mdl_mem[a[13:0]] = d;
        @(posedge clk); #1;
        dl_wr = 1'b0;
    endtask

    task automatic set_trig(input logic [2:0] v);
        @(posedge clk); #1;
        trig   = v;
        m_pend = m_pend | (v & ~m_trig);
        m_trig = v;
    endtask

    // Tick, optionally with a download write at sequence cycle wr_at (1 = RD0).
    task automatic do_tick(input string nm, input int wr_at, input logic [24:0] sa,
                           input logic [7:0] sd, input bit use_lit, input logic [15:0] lit);
        logic [15:0] old;
        bit          qual;
        int          lat;
        qual = (wr_at > 0) && (sa < 25'h4000);
        lat  = qual ? 7 : 6;
        @(posedge clk); #1;
        busy = 1'b1;
        tick = 1'b1;
        old  = exp_audio;
        model_tick();
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            tick    = 1'b0;
            dl_wr   = (k == wr_at);
            dl_addr = sa;
            dl_data = sd;
            if (k == wr_at && qual) mdl_mem[sa[13:0]] = sd;
            @(negedge clk);
            if (k == lat - 1) chk({nm, "_hold"}, 32'(audio_out), 32'(old));
            if (k == lat) begin
                chk({nm, "_mix"}, 32'(audio_out), 32'(m_new_audio));
                if (use_lit) begin
                    chk({nm, "_lit"}, 32'(audio_out), 32'(lit));
                    chk({nm, "_model"}, 32'(m_new_audio), 32'(lit));
                end
            end
        end
        dl_wr      = 1'b0;
        exp_audio  = m_new_audio;
        exp_active = m_act;
        busy       = 1'b0;
        tick_no++;
        $display("tick %0d %s: audio_out=%h voice_active=%b", tick_no, nm, audio_out, voice_active);
    endtask

    task automatic tick_lit(input string nm, input logic [15:0] lit);
        do_tick(nm, 0, 25'h0, 8'h00, 1'b1, lit);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; trig = 3'b000;
        dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        model_reset();
        do_reset();
        checking = 1'b1;
        @(negedge clk);
        chk("reset_audio", 32'(audio_out), 32'h0);
        chk("reset_active", 32'(voice_active), 32'h0);
        chk("reset_we", 32'(rom_we), 32'h0);

        // No triggers: silence.
        tick_lit("idle", 16'h0000);

        // Voice 0: two samples.
        dl_write(25'h0000, 8'hC0);
        dl_write(25'h0001, 8'h40);
        set_trig(3'b001);
        set_trig(3'b000);
        tick_lit("v0_s0", 16'h1000);
        tick_lit("v0_s1", 16'hF000);
        chk("v0_active", 32'(voice_active[0]), 32'h1);

        // Reset in the middle of a sequence.
        @(posedge clk); #1;
        busy = 1'b1;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midrst_active", 32'(voice_active), 32'h0);
        chk("midrst_audio", 32'(audio_out), 32'h0);
        busy = 1'b0;

        // Voice 1 with a three-sample range.
        do_reset();
        dl_write(25'h1000, 8'h90);
        dl_write(25'h1001, 8'hA0);
        dl_write(25'h1002, 8'hB0);
        set_trig(3'b010);
        set_trig(3'b000);
        tick_lit("v1_s0", 16'h0400);
        tick_lit("v1_s1", 16'h0800);
        tick_lit("v1_s2", 16'h0C00);
        chk("v1_done", 32'(voice_active), 32'h0);
        tick_lit("v1_silent", 16'h0000);

        // All voices at full scale.
        do_reset();
        dl_write(25'h0000, 8'hFF);
        dl_write(25'h1000, 8'hFF);
        dl_write(25'h2000, 8'hFF);
        dl_write(25'h0001, 8'h00);
        dl_write(25'h1001, 8'h00);
        dl_write(25'h2001, 8'h00);
        set_trig(3'b111);
        set_trig(3'b000);
        tick_lit("max", 16'h5F40);
        tick_lit("min", 16'hA000);
        chk("all_active", 32'(voice_active), 32'h7);

        // Download write during RD1 stalls the sequence one cycle.
        do_reset();
        dl_write(25'h0000, 8'hC0);
        dl_write(25'h1000, 8'hA0);
        dl_write(25'h0001, 8'h80);
        dl_write(25'h1001, 8'h80);
        set_trig(3'b011);
        set_trig(3'b000);
        do_tick("stall", 2, 25'h0010, 8'h5A, 1'b1, 16'h1800);
        chk("bram_wr", 32'(bram[14'h0010]), 32'h5A);
        // Out-of-range download: no write, no stall.
        do_tick("oor", 2, 25'h4010, 8'hEE, 1'b1, 16'h0000);
        chk("bram_oor", 32'(bram[14'h0010]), 32'h5A);

        // Voice 2 loops while trig[2] held, then ends once released.
        do_reset();
        dl_write(25'h2000, 8'h81);
        dl_write(25'h2001, 8'h82);
        dl_write(25'h2002, 8'h84);
        dl_write(25'h2003, 8'h88);
        set_trig(3'b100);
        tick_lit("v2_a0", 16'h0040);
        tick_lit("v2_a1", 16'h0080);
        tick_lit("v2_a2", 16'h0100);
        tick_lit("v2_a3", 16'h0200);
        chk("v2_wrap_active", 32'(voice_active), 32'h4);
        tick_lit("v2_b0", 16'h0040);
        set_trig(3'b000);
        tick_lit("v2_b1", 16'h0080);
        tick_lit("v2_b2", 16'h0100);
        tick_lit("v2_b3", 16'h0200);
        chk("v2_end_inactive", 32'(voice_active), 32'h0);
        tick_lit("v2_silent", 16'h0000);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/sound_sample_sequencer.md
Name: sound_sample_sequencer

Overview:
- Plays back up to three digitized effect voices (explosion, shell fire, engine) from one shared single-port sample BRAM, and mixes them into a 16-bit signed stream beside the POKEY path.
- Arbitrates the BRAM port between the ROM downloader (ioctl) and the playback sequencer; the downloader always wins.
- Sequences one read per voice on every 48 kHz sample tick.
- Triggers come from output-latch bits decoded by the parent.

Parameters:
ADDR_W, 14, sample BRAM address width
V0_START, 14'h0000, first sample address, voice 0
V0_END, 14'h0FFF, last sample address, voice 0 (inclusive)
V1_START, 14'h1000, first sample address, voice 1
V1_END, 14'h1FFF, last sample address, voice 1
V2_START, 14'h2000, first sample address, voice 2
V2_END, 14'h3FFF, last sample address, voice 2
V2_LOOP, 1, 1 = voice 2 loops while its trigger level is held

Ports:
clk  in  1  system clock; the only clock
rst  in  1  synchronous, active-high reset
clk_48KHz_en  in  1  one-cycle sample tick
trig  in  3  per-voice trigger levels, bit n = voice n
dl_wr  in  1  download write strobe (ioctl_wr qualified by index)
dl_addr  in  25  download byte address
dl_data  in  8  download byte
rom_addr  out  ADDR_W  BRAM address
rom_we  out  1  BRAM write enable
rom_wdata  out  8  BRAM write data
rom_rdata  in  8  BRAM read data, valid 1 cycle after the address
voice_active  out  3  voice n is currently playing
audio_out  out  16  signed mixed output

Behaviour:
- Reset values: all outputs 0, state IDLE, all voices inactive, sample regs 8'h80, pending flags 0, trig history 0.
- Trigger detection, every cycle:
  - A rising edge on trig[n] sets pending[n].
  - Pending is consumed at the next tick that starts a sequence: ptr[n] <= Vn_START, active[n] <= 1, pending[n] <= 0.
  - A retrigger while a voice is active restarts it from START at that tick.
- Sequencer states: IDLE -> RD0 -> RD1 -> RD2 -> CAP -> MIX -> IDLE.
  - IDLE: leaves on clk_48KHz_en (after the pending load above).
  - RDn: drives rom_addr = ptr[n]. Data from RDn is captured in the next state (RD(n+1), or CAP for voice 2).
  - Capture of voice n: if active[n], smp[n] <= rom_rdata and the pointer advances. Otherwise smp[n] <= 8'h80.
  - Pointer advance at ptr == Vn_END:
    - voice 2 with V2_LOOP=1 and trig[2]=1: ptr wraps to V2_START and the voice stays active;
    - all other cases: active[n] <= 0, and the voice is silent from the next tick.
  - Otherwise ptr[n] <= ptr[n] + 1.
  - MIX: audio_out <= {sext10(Σ(smp[n] - 8'h80)), 6'b0}.
    - Each term is signed 8-bit; the sum is signed 10-bit and cannot overflow (range −384..+381).
  - Latency: tick seen in cycle T -> audio_out updates at the end of cycle T+5 (MIX is cycle T+5).
  - A tick arriving while the state is not IDLE is ignored; no queueing.
- Arbitration with the downloader:
  - In a cycle with dl_wr=1: rom_we=1, rom_addr=dl_addr[ADDR_W-1:0], rom_wdata=dl_data.
  - If the sequencer is in RDn in that cycle, it stalls: state and ptr hold, and the read is reissued next cycle.
  - The capture stage ignores rom_rdata in the cycle after a write cycle and holds instead.
  - dl_addr ≥ 2^ADDR_W: no write (rom_we=0) and no stall.
  - rom_we=0 in every cycle without a qualifying dl_wr.
- voice_active mirrors active[] directly.
- rst mid-sequence: returns to IDLE with the reset values above in the next cycle. Any half-issued read is discarded.
- A simultaneous rising edge on trig[n] and END reached for voice n: the pending trigger wins at the next tick, and the voice restarts.

Test Plan:
- Reset, then one tick with no triggers -> audio_out=0, voice_active=0, rom_we never 1.
- Preload BRAM[V0_START..V0_START+1] = 8'hC0, 8'h40; pulse trig[0]; two ticks -> audio_out=16'h1000 at T+5 of the first tick, then 16'hF000 at T+5 of the second; voice_active[0]=1.
- Voice 1 with END set 2 past START -> after 3 ticks voice_active[1]=0, and the 4th tick mixes 8'h80, giving audio_out=0.
- Voices 0–2 all active with samples 8'hFF -> audio_out = 381<<6 = 16'h5F40; all three 8'h00 -> −384<<6 = 16'hA000.
- dl_wr asserted during RD1 (dl_addr=25'h0010, dl_data=8'h5A) -> rom_we=1 with the write address on the port, RD1 reissued the next cycle, MIX delayed one cycle, and BRAM[0x10]=8'h5A.
- Voice 2 with trig[2] held high past V2_END -> ptr wraps to V2_START and voice_active[2] stays 1. Drop trig[2] and let the voice reach END again -> voice_active[2]=0 after the END sample.
